load_store_ramp: RTL and testbench
==================================

# load_store_ramp

- Multi-channel, parametrised load/store ramp generator. It is the successor to the single-channel fixed-limit up/down volume counter.
- Each channel drives a volume counter between 0 and N in steps of STEP, in triangle or sawtooth mode.
- Each channel raises a one-cycle `top` pulse at the peak and a one-cycle `bot` pulse at the floor.
- Sits in the safety-benchmark set as the generalised load/store model; properties are checked on `top`/`bot`.

## Interface

Parameters:
- `NCH`, 4: number of independent channels.
- `CBITS`, 14: counter width.
- `N`, 12500: peak value; must satisfy 1 ≤ N < 2^CBITS.
- `STEP`, 1: increment/decrement per enabled cycle; must satisfy 1 ≤ STEP ≤ N.
- `HOLD`, 0: extra dwell cycles at peak. Only meaningful with `LOAD_STORE_HOLD_EN`.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  NCH  per-channel step enable. When low, the channel freezes.
- `clr`  in  NCH  per-channel synchronous clear. It has priority over `en`.
- `mode`  in  1  global mode: 0 = triangle, 1 = sawtooth.
- `vol`  out  NCH*CBITS  channel counters, channel i at bits [i*CBITS +: CBITS].
- `top`  out  NCH  one-cycle pulse, asserted in the cycle `vol` first equals N.
- `bot`  out  NCH  one-cycle pulse, asserted in the cycle `vol` returns to 0 from a nonzero value.
- `any_top`  out  1  registered OR of `top` across channels.

## Operation

- Each channel has three states: UP, HOLD, DOWN.
- Reset (`rst_n` = 0, asynchronous) sets: `vol` = 0, state UP, `top` = 0, `bot` = 0, `any_top` = 0.
- `clr[i]` = 1: `vol` ← 0, state ← UP, `top[i]` = `bot[i]` = 0 next cycle, irrespective of `en[i]`.
- `en[i]` = 0 and no clear: `vol` and state hold; `top[i]` and `bot[i]` = 0.
- UP, enabled:
  - If `vol` + STEP ≥ N: `vol` ← N and `top` ← 1. Next state is HOLD if hold is enabled and HOLD > 0; otherwise DOWN (triangle) or UP (sawtooth).
  - Otherwise `vol` ← `vol` + STEP.
- UP, sawtooth, `vol` == N: `vol` ← 0, `bot` ← 1, state stays UP.
- DOWN, enabled:
  - If `vol` ≤ STEP: `vol` ← 0, `bot` ← 1, state ← UP.
  - Otherwise `vol` ← `vol` − STEP.
- DOWN while `mode` = 1: next enabled cycle forces `vol` ← 0, `bot` ← 1, state UP.
- Arithmetic:
  - Compare `vol` + STEP in CBITS+1 bits, so no wrap.
  - `vol` never exceeds N and never underflows.
- Pulses:
  - `top` and `bot` are never asserted together on the same channel.
  - `top` is never asserted two consecutive cycles on the same channel.
- `mode` is sampled every cycle; a change affects only the next transition decision.

## Timing

- All outputs are registered. `top[i]` and `bot[i]` are coincident with the `vol` value that caused them.
- `any_top` lags `top` by one cycle.
- Zero-latency response to `en`: the step happens on the same edge that samples `en` = 1.
- First enabled cycle after reset: `vol` = STEP, no `bot` pulse.
- Reset asserted mid-ramp: immediate return to reset values. Counting resumes from 0 on the first enabled edge after deassertion.
- Triangle period is 2·⌈N/STEP⌉ enabled cycles, plus HOLD when that feature is enabled.

## Configuration

- `LOAD_STORE_HOLD_EN` defined:
  - HOLD state is compiled in. After `top`, the channel holds `vol` = N for HOLD enabled cycles, with `top` = 0.
  - It then moves to DOWN (triangle) or emits the wrap to 0 with `bot` (sawtooth).
  - HOLD = 0 behaves as if the state is absent.
- Not defined:
  - HOLD state and its dwell counter are absent; the `HOLD` parameter is ignored.
  - UP transitions directly per Operation.

## Structure

- Package `load_store_pkg` holds:
  - enum `ls_state_t` {`LS_UP`, `LS_HOLD`, `LS_DOWN`};
  - mode constants `LS_TRIANGLE` = 0 and `LS_SAWTOOTH` = 1.
- Sub-module `load_store_chan`: one channel (counter, state, dwell counter, pulses), parametrised by CBITS/N/STEP/HOLD.
- Top level: generate loop instantiating `load_store_chan` NCH times, plus the `any_top` register.

## Test plan

All scenarios use N = 10, STEP = 3, NCH = 2.
- Reset then `en` = 11, `mode` = 0 → `vol[0]` is 3, 6, 9, 10 (`top`), 7, 4, 1, 0 (`bot`), 3; `any_top` follows `top` one cycle later.
- `mode` = 1 from reset → 3, 6, 9, 10 (`top`), 0 (`bot`), 3; `top` never in consecutive cycles.
- `en[1]` toggled 1, 0, 0, 1 with `en[0]` = 1 → channel 1 holds at 3 for two cycles then reaches 6; channel 0 is unaffected.
- `clr[0]` pulsed when `vol[0]` = 7 in DOWN with `en` = 1 → next `vol[0]` = 0, no `bot`, following value 3; `clr` wins over `en`.
- `rst_n` pulled low asynchronously mid-cycle at `vol` = 9 → `vol` = 0, `top` = `bot` = `any_top` = 0 before the next edge.
- With `LOAD_STORE_HOLD_EN` and HOLD = 2 → 9, 10 (`top`), 10, 10, 7. Without the macro, the same bench gives 9, 10 (`top`), 7.

Source files
------------

// File: rtl/load_store_pkg.sv
// Shared types and constants for the load/store ramp generator.
package load_store_pkg;

  typedef enum logic [1:0] {
    LS_UP   = 2'd0,
    LS_HOLD = 2'd1,
    LS_DOWN = 2'd2
  } ls_state_t;

  localparam logic LS_TRIANGLE = 1'b0;
  localparam logic LS_SAWTOOTH = 1'b1;

endpackage

// File: rtl/load_store_chan.sv
// One ramp channel: volume counter, UP/HOLD/DOWN state, dwell counter and pulses.
// The HOLD dwell is compiled in only when LOAD_STORE_HOLD_EN is defined.
module load_store_chan
  import load_store_pkg::*;
#(
  parameter int CBITS = 14,
  parameter int N     = 12500,
  parameter int STEP  = 1,
  parameter int HOLD  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  output logic [CBITS-1:0] vol,
  output logic             top,
  output logic             bot,
  output ls_state_t        state
);

  localparam logic [CBITS-1:0] NV = CBITS'(N);
  localparam logic [CBITS-1:0] SV = CBITS'(STEP);

`ifdef LOAD_STORE_HOLD_EN
  localparam bit HOLD_ON = (HOLD > 0);
  localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0] DLAST = DW'((HOLD > 0) ? HOLD - 1 : 0);
  logic [DW-1:0] dwell, dwell_n;
`else
  // Without the dwell feature the HOLD parameter has no effect.
  localparam bit HOLD_ON = 1'b0 && (HOLD > 0);
`endif

  logic [CBITS-1:0] vol_n;
  logic             top_n, bot_n;
  ls_state_t        state_n;
  logic [CBITS:0]   sum;
  logic             do_down, do_wrap;

  // One extra bit so vol + STEP cannot wrap before the peak compare.
  assign sum = {1'b0, vol} + {1'b0, SV};

  always_comb begin
    vol_n   = vol;
    state_n = state;
    top_n   = 1'b0;
    bot_n   = 1'b0;
    do_down = 1'b0;
    do_wrap = 1'b0;
`ifdef LOAD_STORE_HOLD_EN
    dwell_n = dwell;
`endif
    if (clr) begin
      vol_n   = '0;
      state_n = LS_UP;
`ifdef LOAD_STORE_HOLD_EN
      dwell_n = '0;
`endif
    end else if (en) begin
      case (state)
        LS_UP: begin
          // Sitting at N in UP happens after a sawtooth peak or a dwell exit.
          if (vol == NV) begin
            if (mode == LS_SAWTOOTH) do_wrap = 1'b1;
            else                     do_down = 1'b1;
          end else if (sum >= {1'b0, NV}) begin
            vol_n = NV;
            top_n = 1'b1;
            if (HOLD_ON) begin
              state_n = LS_HOLD;
`ifdef LOAD_STORE_HOLD_EN
              dwell_n = '0;
`endif
            end else if (mode == LS_TRIANGLE) begin
              state_n = LS_DOWN;
            end else begin
              state_n = LS_UP;
            end
          end else begin
            vol_n = sum[CBITS-1:0];
          end
        end
        LS_DOWN: begin
          if (mode == LS_SAWTOOTH) do_wrap = 1'b1;
          else                     do_down = 1'b1;
        end
`ifdef LOAD_STORE_HOLD_EN
        LS_HOLD: begin
          // Leaving with vol still at N lets the following cycle do the step/wrap.
          if (dwell == DLAST) begin
            state_n = (mode == LS_TRIANGLE) ? LS_DOWN : LS_UP;
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end
`endif
        default: state_n = LS_UP;
      endcase

      if (do_wrap) begin
        vol_n   = '0;
        bot_n   = (vol != '0);
        state_n = LS_UP;
      end
      if (do_down) begin
        if (vol <= SV) begin
          vol_n   = '0;
          bot_n   = (vol != '0);
          state_n = LS_UP;
        end else begin
          vol_n   = vol - SV;
          state_n = LS_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol   <= '0;
      state <= LS_UP;
      top   <= 1'b0;
      bot   <= 1'b0;
`ifdef LOAD_STORE_HOLD_EN
      dwell <= '0;
`endif
    end else begin
      vol   <= vol_n;
      state <= state_n;
      top   <= top_n;
      bot   <= bot_n;
`ifdef LOAD_STORE_HOLD_EN
      dwell <= dwell_n;
`endif
    end
  end

endmodule

// File: rtl/load_store_ramp.sv
// Multi-channel load/store ramp generator; NCH independent channels plus a
// registered any_top flag. Optional peak dwell via LOAD_STORE_HOLD_EN.
module load_store_ramp
  import load_store_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CBITS = 14,
  parameter int N     = 12500,
  parameter int STEP  = 1,
  parameter int HOLD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       clr,
  input  logic                 mode,
  output logic [NCH*CBITS-1:0] vol,
  output logic [NCH-1:0]       top,
  output logic [NCH-1:0]       bot,
  output logic                 any_top,
  output logic [2*NCH-1:0]     dbg_state
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ls_state_t st;

    load_store_chan #(
      .CBITS (CBITS),
      .N     (N),
      .STEP  (STEP),
      .HOLD  (HOLD)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[i]),
      .clr   (clr[i]),
      .mode  (mode),
      .vol   (vol[i*CBITS +: CBITS]),
      .top   (top[i]),
      .bot   (bot[i]),
      .state (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_top <= 1'b0;
    else        any_top <= |top;
  end

endmodule

// File: tb/tb_load_store_ramp.sv
// Table-driven bench for load_store_ramp with N=10, STEP=3, NCH=2, HOLD=2.
module tb_load_store_ramp;

  localparam int NCH   = 2;
  localparam int CBITS = 14;
  localparam int W     = NCH * CBITS + 5;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       clr;
  logic                 mode;
  logic [NCH*CBITS-1:0] vol;
  logic [NCH-1:0]       top;
  logic [NCH-1:0]       bot;
  logic                 any_top;
  logic [2*NCH-1:0]     dbg_state;

  load_store_ramp #(
    .NCH   (NCH),
    .CBITS (CBITS),
    .N     (10),
    .STEP  (3),
    .HOLD  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .mode      (mode),
    .vol       (vol),
    .top       (top),
    .bot       (bot),
    .any_top   (any_top),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit             pre;
    logic [1:0]     en;
    logic [1:0]     clr;
    logic           mode;
    logic [13:0]    v0;
    logic [13:0]    v1;
    logic [1:0]     top;
    logic [1:0]     bot;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  logic [1:0]   prev_top;
  int           nvec;
  int           nmis;

  function automatic vec_t mk(bit pre, logic [1:0] e, logic [1:0] c, logic m,
                              int a, int b, logic [1:0] t, logic [1:0] bt);
    vec_t v;
    v.pre  = pre;
    v.en   = e;
    v.clr  = c;
    v.mode = m;
    v.v0   = 14'(a);
    v.v1   = 14'(b);
    v.top  = t;
    v.bot  = bt;
    return v;
  endfunction

  function automatic void add(bit pre, logic [1:0] e, logic [1:0] c, logic m,
                              int a, int b, logic [1:0] t, logic [1:0] bt);
    tbl.push_back(mk(pre, e, c, m, a, b, t, bt));
  endfunction

  // scoreboard
  task automatic check(input string nm);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {vol, top, bot, any_top};
    nvec++;
    if (exp_q.size() == 0) begin
      nmis++;
      $display("FAIL %s: no expected entry queued", nm);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e) begin
      nmis++;
      $display("FAIL %s: got vol1=%0d vol0=%0d top=%b bot=%b any_top=%b, expected vol1=%0d vol0=%0d top=%b bot=%b any_top=%b",
               nm, got[32:19], got[18:5], got[4:3], got[2:1], got[0],
               e[32:19], e[18:5], e[4:3], e[2:1], e[0]);
    end
  endtask

  // drivers
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    en    = '0;
    clr   = '0;
    mode  = 1'b0;
    prev_top = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check(nm);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string nm);
    en   = v.en;
    clr  = v.clr;
    mode = v.mode;
    exp_q.push_back({v.v1, v.v0, v.top, v.bot, |prev_top});
    prev_top = v.top;
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst_n = 1'b0;
    en = '0;
    clr = '0;
    mode = 1'b0;
    prev_top = '0;

    // triangle, both channels enabled
    add(1, 2'b11, 2'b00, 0,  3,  3, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  6,  6, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  9,  9, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b11, 2'b00);
`ifdef LOAD_STORE_HOLD_EN
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b00, 2'b00);
`endif
    add(0, 2'b11, 2'b00, 0,  7,  7, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  4,  4, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  1,  1, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  0,  0, 2'b00, 2'b11);
    add(0, 2'b11, 2'b00, 0,  3,  3, 2'b00, 2'b00);

    // sawtooth, two periods: top never on consecutive cycles
    add(1, 2'b11, 2'b00, 1,  3,  3, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1,  6,  6, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1,  9,  9, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b11, 2'b00);
`ifdef LOAD_STORE_HOLD_EN
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b00, 2'b00);
`endif
    add(0, 2'b11, 2'b00, 1,  0,  0, 2'b00, 2'b11);
    add(0, 2'b11, 2'b00, 1,  3,  3, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1,  6,  6, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1,  9,  9, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b11, 2'b00);
`ifdef LOAD_STORE_HOLD_EN
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 1, 10, 10, 2'b00, 2'b00);
`endif
    add(0, 2'b11, 2'b00, 1,  0,  0, 2'b00, 2'b11);

    // per-channel enable: channel 1 freezes for two cycles
    add(1, 2'b11, 2'b00, 0,  3,  3, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 0,  6,  3, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 0,  9,  3, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0, 10,  6, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 0, 10,  6, 2'b00, 2'b00);

    // clear wins over enable, no bot on clear
    add(1, 2'b11, 2'b00, 0,  3,  3, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  6,  6, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  9,  9, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b11, 2'b00);
`ifdef LOAD_STORE_HOLD_EN
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0, 10, 10, 2'b00, 2'b00);
`endif
    add(0, 2'b11, 2'b00, 0,  7,  7, 2'b00, 2'b00);
    add(0, 2'b11, 2'b01, 0,  0,  4, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  3,  1, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  6,  0, 2'b00, 2'b10);
    add(0, 2'b00, 2'b10, 0,  6,  0, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 0,  9,  3, 2'b00, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre) do_reset($sformatf("reset_before_vec%0d", i));
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a cycle at vol = 9
    do_reset("reset_before_async");
    apply(mk(0, 2'b11, 2'b00, 0, 3, 3, 2'b00, 2'b00), "async_pre3");
    apply(mk(0, 2'b11, 2'b00, 0, 6, 6, 2'b00, 2'b00), "async_pre6");
    apply(mk(0, 2'b11, 2'b00, 0, 9, 9, 2'b00, 2'b00), "async_pre9");
    #2;
    rst_n = 1'b0;
    #1;
    prev_top = '0;
    exp_q.push_back('0);
    check("async_rst_immediate");
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    check("async_rst_held");
    rst_n = 1'b1;
    apply(mk(0, 2'b11, 2'b00, 0, 3, 3, 2'b00, 2'b00), "async_resume");

    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
